// File: rtl/sdp_ram_streamer.sv
// Streams a run of words from a simple-dual-port RAM read port onto an AXI4-Stream master.
// A credit-limited FIFO absorbs the RAM read latency so backpressure never drops or repeats data.
module sdp_ram_streamer #(
    parameter int DW         = 512,
    parameter int DD         = 16384,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(DD)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [AW-1:0] first_addr,
    input  logic [AW:0]   word_count,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] addrb,
    input  logic [DW-1:0] dob,
    output logic [DW-1:0] M_AXIS_TDATA,
    output logic          M_AXIS_TVALID,
    output logic          M_AXIS_TLAST,
    input  logic          M_AXIS_TREADY
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW:0]   DD_W    = (AW + 1)'(DD);
    localparam logic [AW:0]   ONE_W   = (AW + 1)'(1);
    localparam logic [AW-1:0] LAST_AD = AW'(DD - 1);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [AW:0]    count_clamped;
    logic [AW:0]    reads_left;
    logic [AW:0]    beats_left;
    logic [CW-1:0]  in_flight;
    logic [CW-1:0]  fifo_count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [DW-1:0]  fifo_mem [FIFO_DEPTH];
    logic           addr_vld;
    logic [RD_LAT-1:0] dly;
    logic           credit_ok;
    logic           issue_first;
    logic           issue_run;
    logic           issue;
    logic           push;
    logic           fire;
    logic           last_fire;

    assign count_clamped = (word_count > DD_W) ? DD_W : word_count;
    // Credit counts reads already issued but not yet landed, so the FIFO cannot overflow.
    assign credit_ok     = ({1'b0, in_flight} + {1'b0, fifo_count}) < CREDITS;
    assign push          = dly[RD_LAT-1];
    assign M_AXIS_TVALID = (fifo_count != '0);
    assign M_AXIS_TDATA  = fifo_mem[rd_ptr];
    assign M_AXIS_TLAST  = M_AXIS_TVALID && (beats_left == ONE_W);
    assign fire          = M_AXIS_TVALID && M_AXIS_TREADY;
    assign last_fire     = fire && (beats_left == ONE_W);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && count_clamped != '0)
                    state_nxt = (count_clamped == ONE_W) ? DRAIN : RUN;
            end
            RUN: begin
                if (credit_ok && reads_left == ONE_W) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        issue_first = (state == IDLE) && start && (count_clamped != '0);
        issue_run   = (state == RUN) && credit_ok;
        issue       = issue_first || issue_run;
    end

    // The first read is issued on the start edge so addrb holds first_addr one cycle later.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            addrb      <= '0;
            reads_left <= '0;
            beats_left <= '0;
            done       <= 1'b0;
            addr_vld   <= 1'b0;
            dly        <= '0;
            in_flight  <= '0;
        end else begin
            if (issue_first) begin
                addrb      <= first_addr;
                reads_left <= count_clamped - ONE_W;
            end else if (issue_run) begin
                addrb      <= (addrb == LAST_AD) ? '0 : addrb + 1'b1;
                reads_left <= reads_left - ONE_W;
            end
            if (issue_first)
                beats_left <= count_clamped;
            else if (fire)
                beats_left <= beats_left - ONE_W;
            done      <= ((state == DRAIN) && last_fire) ||
                         ((state == IDLE) && start && (count_clamped == '0));
            addr_vld  <= issue;
            dly[0]    <= addr_vld;
            for (int i = 1; i < RD_LAT; i++)
                dly[i] <= dly[i-1];
            in_flight <= in_flight + CW'(issue) - CW'(push);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (fire) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(fire);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= dob;
    end

endmodule

// File: tb/tb_sdp_ram_streamer.sv
// Directed bench for sdp_ram_streamer with a 16-word RAM model (RAM[i]=i, two-cycle read)
// and a scoreboard of expected stream beats.
module tb_sdp_ram_streamer;

    localparam int DW = 32;
    localparam int DD = 16;
    localparam int AW = 4;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dob;
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tlast;
    logic          tready = 1'b1;

    logic [31:0] ram [DD];
    logic [31:0] ram_q;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;
    int   failed = 0;
    int   cyc = 0;
    int   beats = 0;
    int   done_cnt = 0;
    int   start_cyc = 0;
    int   first_valid_cyc = -1;
    int   first_fire_cyc = -1;
    int   last_fire_cyc = -1;
    int   done_cyc = -1;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;

    sdp_ram_streamer #(.DW(DW), .DD(DD), .RD_LAT(2), .FIFO_DEPTH(8)) dut (
        .clk(clk), .resetn(resetn), .start(start), .first_addr(first_addr),
        .word_count(word_count), .busy(busy), .done(done), .addrb(addrb), .dob(dob),
        .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TLAST(tlast),
        .M_AXIS_TREADY(tready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle RAM read: address in cycle n, data on dob in cycle n+2.
    always @(posedge clk) begin
        ram_q <= ram[addrb];
        dob   <= ram_q;
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: hold-stability checks during stalls and scoreboard pops on handshakes.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_output("hold_valid", 64'(tvalid), 64'd1);
                check_output("hold_data", 64'(tdata), 64'(prev_data));
                check_output("hold_last", 64'(tlast), 64'(prev_last));
            end
            if (tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (tvalid && tready) begin
                check_output("beat_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check_output("beat_data", 64'(tdata), 64'(e.d));
                    check_output("beat_last", 64'(tlast), 64'(e.l));
                end
                beats++;
                if (first_fire_cyc < 0) first_fire_cyc = cyc;
                last_fire_cyc = cyc;
            end
            if (!tready) check_output("fifo_fill_le_8", 64'(dut.fifo_count <= 8), 64'd1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    task automatic apply_stimulus(input int addr, input int cnt, input int nexp);
        for (int i = 0; i < nexp; i++)
            sb.push_back('{d: 32'((addr + i) % DD), l: (i == nexp - 1)});
        beats = 0;
        first_valid_cyc = -1;
        first_fire_cyc = -1;
        last_fire_cyc = -1;
        @(posedge clk); #1;
        first_addr = AW'(addr);
        word_count = (AW + 1)'(cnt);
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            if (done_cnt != d0) break;
        end
        check_output(tag, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < DD; i++) ram[i] = 32'(i);

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_addrb", 64'(addrb), 64'd0);
        check_output("rst_tvalid", 64'(tvalid), 64'd0);
        check_output("rst_tlast", 64'(tlast), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // 1: full run, latency and back-to-back beats
        apply_stimulus(0, 16, 16);
        check_output("t1_busy", 64'(busy), 64'd1);
        wait_done("t1_done", 100);
        check_output("t1_latency", 64'(first_valid_cyc - start_cyc), 64'd4);
        check_output("t1_no_bubbles", 64'(last_fire_cyc - first_fire_cyc), 64'd15);
        check_output("t1_done_timing", 64'(done_cyc - last_fire_cyc), 64'd1);
        check_output("t1_beats", 64'(beats), 64'd16);
        check_output("t1_sb_empty", 64'(sb.size()), 64'd0);

        // 2: wrap-around
        apply_stimulus(14, 4, 4);
        wait_done("t2_done", 100);
        check_output("t2_beats", 64'(beats), 64'd4);

        // 3: random backpressure, then a long stall
        sb.delete();
        apply_stimulus(0, 16, 16);
        for (int i = 0; i < 10; i++) begin
            tready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        tready = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        tready = 1'b1;
        wait_done("t3_done", 200);
        check_output("t3_beats", 64'(beats), 64'd16);
        check_output("t3_sb_empty", 64'(sb.size()), 64'd0);

        // 4: zero-length run, then an oversize count clamped to DD
        apply_stimulus(0, 0, 0);
        check_output("t4_zero_busy", 64'(busy), 64'd0);
        wait_done("t4_zero_done", 10);
        check_output("t4_zero_timing", 64'(done_cyc - start_cyc), 64'd1);
        repeat (5) @(posedge clk);
        check_output("t4_zero_beats", 64'(beats), 64'd0);
        check_output("t4_zero_tvalid_seen", 64'(first_valid_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        apply_stimulus(0, 20, 16);
        wait_done("t4_clamp_done", 100);
        check_output("t4_clamp_beats", 64'(beats), 64'd16);

        // 5: single beat, then a start during a run must be ignored
        apply_stimulus(7, 1, 1);
        wait_done("t5_single_done", 50);
        check_output("t5_single_beats", 64'(beats), 64'd1);
        apply_stimulus(0, 8, 8);
        repeat (2) @(posedge clk);
        #1;
        first_addr = 4'd9;
        word_count = 5'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5_run_done", 100);
        check_output("t5_run_beats", 64'(beats), 64'd8);
        repeat (10) @(posedge clk);
        check_output("t5_no_extra_beats", 64'(beats), 64'd8);
        check_output("t5_idle_busy", 64'(busy), 64'd0);

        // 6: reset mid-run, then a fresh short run
        apply_stimulus(0, 16, 16);
        for (int i = 0; i < 100 && beats < 5; i++) begin
            @(negedge clk); #1;
        end
        check_output("t6_reached_beat5", 64'(beats), 64'd5);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("t6_rst_tvalid", 64'(tvalid), 64'd0);
        check_output("t6_rst_busy", 64'(busy), 64'd0);
        check_output("t6_rst_addrb", 64'(addrb), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        apply_stimulus(3, 2, 2);
        wait_done("t6_done", 50);
        check_output("t6_beats", 64'(beats), 64'd2);
        check_output("t6_sb_empty", 64'(sb.size()), 64'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
